dmem_port_arbiter: RTL and testbench

Shares the single byte-wide data memory between two requesters: port 0 (CPU load/store unit) and port 1 (debug/DMA loader). Each granted access of byte, halfword or word size is sequenced as consecutive one-byte memory cycles in big-endian order, with sign- or zero-extension on reads. Sits between the requesters and a 1024 x 8 synchronous RAM that has a one-cycle read latency.

---
 rtl/dmem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter that shares a byte-wide synchronous RAM between two requesters,
// sequencing byte/half/word accesses as big-endian byte cycles with load extension.
module dmem_port_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic        p0_sign,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic        p1_sign,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic        busy,
  output logic        mem_en,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned KW = 3;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, ACK} state_t;

  state_t          state;
  logic            last_grant;
  logic            gnt;
  logic            we_q;
  logic            sign_q;
  logic [1:0]      size_q;
  logic [KW-1:0]   n_q;
  logic [KW-1:0]   k;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [23:0]     asm_q;

  logic            sel_c;
  logic            in_we_c;
  logic [1:0]      in_size_c;
  logic            in_sign_c;
  logic [AW-1:0]   in_addr_c;
  logic [DW-1:0]   in_wdata_c;
  logic [KW-1:0]   in_n_c;
  logic [DW-1:0]   fin_c;
  logic [DW-1:0]   result_c;
  logic            addr_hi_unused_c;

  function automatic logic [KW-1:0] num_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return KW'(4);
      2'b01:   return KW'(2);
      default: return KW'(1);
    endcase
  endfunction

  // Byte i of an n-byte store, most-significant byte first.
  function automatic logic [7:0] store_byte(input logic [DW-1:0] wd, input logic [KW-1:0] n,
                                            input logic [KW-1:0] i);
    logic [4:0] sh;
    sh = {2'(n - i - KW'(1)), 3'b000};
    return 8'(wd >> sh);
  endfunction

  // Port 1 wins when alone, or in contention when port 0 was granted last.
  assign sel_c      = p1_req & (~p0_req | ~last_grant);
  assign in_we_c    = sel_c ? p1_we : p0_we;
  assign in_size_c  = sel_c ? p1_size : p0_size;
  assign in_sign_c  = sel_c ? p1_sign : p0_sign;
  assign in_addr_c  = sel_c ? p1_addr[AW-1:0] : p0_addr[AW-1:0];
  assign in_wdata_c = sel_c ? p1_wdata : p0_wdata;
  assign in_n_c     = num_bytes(in_size_c);
  assign addr_hi_unused_c = ^{p0_addr[DW-1:AW], p1_addr[DW-1:AW]};

  // Final byte arrives during DRAIN; extend according to the latched size.
  assign fin_c = {asm_q, mem_rdata};

  always_comb begin
    result_c = fin_c;
    case (size_q)
      2'b00:   result_c = fin_c;
      2'b01:   result_c = {{16{sign_q & fin_c[15]}}, fin_c[15:0]};
      default: result_c = {{24{sign_q & fin_c[7]}}, fin_c[7:0]};
    endcase
  end

  // k counts bytes already strobed; byte 0 is launched on the grant edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      we_q       <= 1'b0;
      sign_q     <= 1'b0;
      size_q     <= 2'b00;
      n_q        <= '0;
      k          <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      asm_q      <= '0;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
      busy       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (p0_req | p1_req) begin
            gnt        <= sel_c;
            last_grant <= sel_c;
            we_q       <= in_we_c;
            size_q     <= in_size_c;
            sign_q     <= in_sign_c;
            addr_q     <= in_addr_c;
            wdata_q    <= in_wdata_c;
            n_q        <= in_n_c;
            k          <= KW'(1);
            asm_q      <= '0;
            mem_en     <= 1'b1;
            mem_we     <= in_we_c;
            mem_addr   <= in_addr_c;
            mem_wdata  <= store_byte(in_wdata_c, in_n_c, KW'(0));
            busy       <= 1'b1;
            state      <= XFER;
          end
        end
        XFER: begin
          if (!we_q && k >= KW'(2)) asm_q <= {asm_q[15:0], mem_rdata};
          if (k == n_q) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (we_q) begin
              p0_ack <= ~gnt;
              p1_ack <= gnt;
              state  <= ACK;
            end else begin
              state  <= DRAIN;
            end
          end else begin
            mem_addr  <= addr_q + AW'(k);
            mem_wdata <= store_byte(wdata_q, n_q, k);
            k         <= k + KW'(1);
          end
        end
        DRAIN: begin
          if (gnt) p1_rdata <= result_c;
          else     p0_rdata <= result_c;
          p0_ack <= ~gnt;
          p1_ack <= gnt;
          state  <= ACK;
        end
        ACK: begin
          busy  <= 1'b0;
          k     <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: byte-level RAM model, per-port expected-ack
// queues and an expected-strobe queue filled by a byte-array reference model.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        p0_req = 0, p0_we = 0, p0_sign = 0;
  logic [1:0]  p0_size = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0;
  logic        p1_req = 0, p1_we = 0, p1_sign = 0;
  logic [1:0]  p1_size = 0;
  logic [31:0] p1_addr = 0, p1_wdata = 0;
  logic        p0_ack, p1_ack, busy, mem_en, mem_we;
  logic [31:0] p0_rdata, p1_rdata;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_sign(p0_sign),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_sign(p1_sign),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct { logic [31:0] rdata; int cyc; bit chk; } ack_t;
  typedef struct { int cyc; logic we; logic [9:0] addr; logic [7:0] data; } stb_t;

  logic [7:0]  ram     [1024];
  logic [7:0]  ref_mem [1024];
  logic [31:0] last_exp [2];
  ack_t        ack_q0[$], ack_q1[$];
  stb_t        stb_q[$];
  int          ack_log[$];
  bit          strict = 1'b0;
  bit          log_en = 1'b0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // 1024 x 8 synchronous RAM, one-cycle read latency.
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    forever begin
      @(posedge clk);
      if (mem_en === 1'b1) begin
        if (mem_we) ram[mem_addr] = mem_wdata;
        else        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Reference model: byte-addressed array, big-endian assembly by arithmetic.
  task automatic model_push(input int p, input logic we, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd, input int start);
    int n, ai;
    longint unsigned v;
    logic [7:0] b;
    ack_t e;
    n = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
    v = 0;
    for (int i = 0; i < n; i++) begin
      ai = (int'(a[9:0]) + i) % 1024;
      if (we) begin
        b = 8'((longint'(wd) >> (8 * (n - 1 - i))) & 255);
        ref_mem[ai] = b;
      end else begin
        b = ref_mem[ai];
        v = v * 256 + longint'(b);
      end
      if (strict) stb_q.push_back('{start + 1 + i, we, 10'(ai), we ? b : 8'h00});
    end
    if (!we) begin
      if (sg && v >= (64'd1 << (8 * n - 1))) v = v + (64'd1 << 32) - (64'd1 << (8 * n));
      last_exp[p] = 32'(v);
    end
    e.rdata = last_exp[p];
    e.cyc   = start + n + (we ? 1 : 2);
    e.chk   = strict;
    if (p == 0) ack_q0.push_back(e);
    else        ack_q1.push_back(e);
  endtask

  task automatic set_port(input int p, input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      p0_we = we; p0_size = sz; p0_sign = sg; p0_addr = a; p0_wdata = wd; p0_req = 1'b1;
    end else begin
      p1_we = we; p1_size = sz; p1_sign = sg; p1_addr = a; p1_wdata = wd; p1_req = 1'b1;
    end
    model_push(p, we, sz, sg, a, wd, cyc);
  endtask

  task automatic wait_ack(input int p, output logic [31:0] got);
    int t;
    t = 0;
    got = 'x;
    forever begin
      @(negedge clk);
      if ((p == 0 ? p0_ack : p1_ack) === 1'b1) begin
        got = (p == 0) ? p0_rdata : p1_rdata;
        break;
      end
      t++;
      if (t > 40) begin
        n_tests++;
        n_fail++;
        $display("FAIL ack_timeout: port %0d got no ack in %0d cycles, required one", p, t);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input int p, input logic we, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
    set_port(p, we, sz, sg, a, wd);
    wait_ack(p, got);
    if (p == 0) p0_req = 1'b0;
    else        p1_req = 1'b0;
  endtask

  task automatic mon_ack(input int p, input logic [31:0] rd);
    ack_t e;
    n_tests++;
    if ((p == 0 ? ack_q0.size() : ack_q1.size()) == 0) begin
      n_fail++;
      $display("FAIL spurious_ack: port %0d ack at cycle %0d, required none", p, cyc);
      return;
    end
    e = (p == 0) ? ack_q0.pop_front() : ack_q1.pop_front();
    if (rd !== e.rdata || (e.chk && cyc != e.cyc)) begin
      n_fail++;
      $display("FAIL ack_p%0d: got rdata %h cycle %0d, required rdata %h cycle %0d",
               p, rd, cyc, e.rdata, e.chk ? e.cyc : cyc);
    end
    if (log_en) ack_log.push_back(p);
  endtask

  // Monitor: pops expectations whenever the DUT acks or strobes memory.
  always @(negedge clk) begin
    if (rst_n) begin
      if (p0_ack === 1'b1 && p1_ack === 1'b1) begin
        n_tests++;
        n_fail++;
        $display("FAIL dual_ack: both acks high at cycle %0d, required at most one", cyc);
      end
      if (p0_ack === 1'b1) mon_ack(0, p0_rdata);
      if (p1_ack === 1'b1) mon_ack(1, p1_rdata);
      if (mem_en === 1'b1 && strict) begin
        stb_t s;
        n_tests++;
        if (stb_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_strobe: addr %h at cycle %0d, required none", mem_addr, cyc);
        end else begin
          s = stb_q.pop_front();
          if (cyc != s.cyc || mem_we !== s.we || mem_addr !== s.addr || busy !== 1'b1 ||
              (s.we && mem_wdata !== s.data)) begin
            n_fail++;
            $display("FAIL strobe: got cyc %0d we %b addr %h data %h busy %b, required cyc %0d we %b addr %h data %h busy 1",
                     cyc, mem_we, mem_addr, mem_wdata, busy, s.cyc, s.we, s.addr, s.data);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] got, a;
    int bad;
    last_exp[0] = '0;
    last_exp[1] = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_p0_ack", 32'(p0_ack), 0);
    check("rst_p1_ack", 32'(p1_ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_p0_rdata", p0_rdata, 0);
    check("rst_p1_rdata", p1_rdata, 0);
    repeat (3) @(posedge clk);
    for (int i = 0; i < 1024; i++) ref_mem[i] = ram[i];
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention from reset: both held high, grants must alternate starting with port 0.
    strict = 1'b0;
    log_en = 1'b1;
    fork
      begin
        for (int t = 0; t < 4; t++) begin
          set_port(0, 1'b0, 2'($urandom), 1'($urandom), $urandom, 0);
          wait_ack(0, got);
        end
        p0_req = 1'b0;
      end
      begin
        for (int t = 0; t < 4; t++) begin
          set_port(1, 1'b0, 2'($urandom), 1'($urandom), $urandom, 0);
          wait_ack(1, got);
        end
        p1_req = 1'b0;
      end
    join
    log_en = 1'b0;
    check("ack_order_len", 32'(ack_log.size()), 8);
    for (int t = 0; t < 8; t++)
      if (t < ack_log.size()) check("ack_order", 32'(ack_log[t]), 32'(t % 2));

    strict = 1'b1;
    txn(0, 1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'h1234_5678, got);
    txn(0, 1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0, got);
    check("word_load", got, 32'h1234_5678);

    txn(1, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h0000_0080, got);
    txn(1, 1'b1, 2'b10, 1'b0, 32'hFFFF_F021, 32'h0000_0001, got);
    txn(0, 1'b0, 2'b01, 1'b1, 32'h0000_0020, 32'h0, got);
    check("half_sx", got, 32'hFFFF_8001);
    txn(0, 1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h0, got);
    check("half_zx", got, 32'h0000_8001);
    txn(1, 1'b0, 2'b10, 1'b1, 32'h0000_0020, 32'h0, got);
    check("byte_sx", got, 32'hFFFF_FF80);
    txn(1, 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, got);
    check("byte_zx", got, 32'h0000_0080);

    txn(1, 1'b1, 2'b00, 1'b0, 32'h0000_03FE, 32'hAABB_CCDD, got);
    txn(0, 1'b0, 2'b00, 1'b0, 32'h0000_03FE, 32'h0, got);
    check("wrap_word", got, 32'hAABB_CCDD);

    txn(0, 1'b1, 2'b11, 1'b0, 32'h0000_0055, 32'h0000_00EE, got);
    txn(0, 1'b0, 2'b10, 1'b0, 32'h0000_0055, 32'h0, got);
    check("size11_byte", got, 32'h0000_00EE);

    for (int t = 0; t < 200; t++) begin
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a[9:0] = 10'h3FC + 10'($urandom_range(0, 3));
      txn(int'($urandom_range(0, 1)), 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, got);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Abort a word store after its second byte lands.
    strict = 1'b0;
    p0_we = 1'b1; p0_size = 2'b00; p0_sign = 1'b0;
    p0_addr = 32'h0000_0100; p0_wdata = 32'hCAFE_F00D; p0_req = 1'b1;
    repeat (3) @(posedge clk);
    ref_mem[10'h100] = 8'hCA;
    ref_mem[10'h101] = 8'hFE;
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_mem_en", 32'(mem_en), 0);
    check("abort_ack", 32'(p0_ack), 0);
    p0_req = 1'b0;
    last_exp[0] = '0;
    last_exp[1] = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    strict = 1'b1;
    txn(1, 1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0, got);
    check("abort_bytes", {16'h0, got[31:16]}, 32'h0000_CAFE);
    for (int t = 0; t < 20; t++)
      txn(int'($urandom_range(0, 1)), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, got);

    repeat (4) @(posedge clk);
    #1;
    check("ackq0_empty", 32'(ack_q0.size()), 0);
    check("ackq1_empty", 32'(ack_q1.size()), 0);
    check("stbq_empty", 32'(stb_q.size()), 0);
    bad = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) bad++;
    check("mem_image_bad_bytes", 32'(bad), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
